// File: rtl/mod53_inv_const_mul_seq.sv
// Bit-serial MSB-first constant multiply modulo MOD (default: x*31 mod 53, inverse of x*65).
// Valid/ready on both sides; one residue in flight, result held until consumed.
//   state | meaning
//   IDLE  | ready for a new residue
//   RUN   | one shift-add-reduce step per cycle over the bits of K
//   DONE  | result presented, waiting for out_ready
module mod53_inv_const_mul_seq #(
  parameter int MOD = 53,
  parameter int W   = 6,
  parameter int K   = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_oor,
  output logic         busy
);

  localparam int           CW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0]   MOD_X = (W+1)'(MOD);
  localparam logic [W-1:0] MOD_W = W'(MOD);
  localparam logic [W-1:0] K_V   = W'(K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_r;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_oor;
  logic          r_busy;

  logic [W-1:0]  w_dbl_red;
  logic [W-1:0]  w_sum_red;
  logic [W-1:0]  w_acc_nxt;
  logic [W-1:0]  w_r_load;
  logic          w_oor;

  // Any v < 2*MOD reduces with one conditional subtract; the true result fits in W bits.
  function automatic logic [W-1:0] red(input logic [W:0] v);
    return (v >= MOD_X) ? (v[W-1:0] - MOD_W) : v[W-1:0];
  endfunction

  always_comb begin
    w_dbl_red = red({r_acc, 1'b0});
    w_sum_red = red({1'b0, w_dbl_red} + {1'b0, r_r});
    w_acc_nxt = K_V[r_cnt] ? w_sum_red : w_dbl_red;
    w_oor     = ({1'b0, in_data} >= MOD_X);
    w_r_load  = red({1'b0, in_data});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_r         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_oor       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_r        <= w_r_load;
            r_oor      <= w_oor;
            r_acc      <= '0;
            r_cnt      <= CW'(W-1);
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_nxt;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_oor   = r_oor;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mod53_inv_const_mul_seq.sv
// Bench for mod53_inv_const_mul_seq: vector table, sweeps and corner sequences,
// with results checked against a scoreboard queue filled when each input is driven.
module tb_mod53_inv_const_mul_seq;
  localparam int W   = 6;
  localparam int MOD = 53;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_oor;
  logic         busy;

  mod53_inv_const_mul_seq #(.MOD(MOD), .W(W), .K(31)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_oor(out_oor), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         oor;
    int           acc;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  int   pops = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         oor;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int inv_model(input int x);
    int r;
    r = (x >= MOD) ? x - MOD : x;
    return (r * 31) % MOD;
  endfunction

  // Monitor: inputs change only at posedge+2, so a negedge handshake view holds at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      if (!out_valid) chk("out_data_zero_when_invalid", out_data, 0);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data %0d with empty scoreboard", out_data);
        end else begin
          m_e = sb.pop_front();
          pops++;
          if (out_data !== m_e.data || out_oor !== m_e.oor) begin
            errors++;
            $display("FAIL result: got data %0d oor %0d expected data %0d oor %0d",
                     out_data, out_oor, m_e.data, m_e.oor);
          end
          chk("latency", rise_cyc - m_e.acc, W);
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] ed, input logic eo,
                      input logic hold, output int acc);
    logic ok;
    exp_t e;
    ok = 1'b0;
    acc = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never 1 for input %0d", d);
    end else begin
      acc = cyc + 1;
      e.data = ed;
      e.oor  = eo;
      e.acc  = acc;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int n;
    int p0;
    int acc_b2b[5];
    logic [W-1:0] b2b_in[5];
    logic [W-1:0] b2b_out[5];
    logic         b2b_oor[5];

    vecs[0] = '{din: 6'd12, dout: 6'd1,  oor: 1'b0};
    vecs[1] = '{din: 6'd1,  dout: 6'd31, oor: 1'b0};
    vecs[2] = '{din: 6'd0,  dout: 6'd0,  oor: 1'b0};
    vecs[3] = '{din: 6'd52, dout: 6'd22, oor: 1'b0};
    vecs[4] = '{din: 6'd2,  dout: 6'd9,  oor: 1'b0};
    vecs[5] = '{din: 6'd60, dout: 6'd5,  oor: 1'b1};
    vecs[6] = '{din: 6'd53, dout: 6'd0,  oor: 1'b1};
    vecs[7] = '{din: 6'd63, dout: 6'd45, oor: 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_oor", out_oor, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // First transaction: in_ready low for exactly W+1 cycles.
    send(6'd12, 6'd1, 1'b0, 1'b0, a);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    chk("in_ready_low_cycles", n, W + 1);
    drain();

    foreach (vecs[i]) begin
      send(vecs[i].din, vecs[i].dout, vecs[i].oor, 1'b0, a);
      drain();
    end

    for (int x = 0; x < MOD; x++) begin
      send(W'(x), W'(inv_model(x)), 1'b0, 1'b0, a);
      drain();
    end

    // Round trip: forward multiply-by-65 then the DUT must return the original residue.
    for (int x = 0; x < MOD; x++) begin
      send(W'((x * 65) % MOD), W'(x), 1'b0, 1'b0, a);
      drain();
    end

    // Backpressure with a rejected input during the stall.
    out_ready = 1'b0;
    send(6'd12, 6'd1, 1'b0, 1'b0, a);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (i == 2) begin
        in_valid = 1'b1;
        in_data  = 6'd7;
      end
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after_consume_in_ready", in_ready, 1);
    chk("after_consume_out_valid", out_valid, 0);
    chk("after_consume_busy", busy, 0);
    chk("stall_scoreboard_empty", sb.size(), 0);
    @(posedge clk);
    #2;

    // Reset asserted at the third iteration edge.
    send(6'd63, 6'd45, 1'b1, 1'b0, a);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_oor", out_oor, 0);
    chk("midrst_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    send(6'd12, 6'd1, 1'b0, 1'b0, a);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    b2b_in  = '{6'd12, 6'd60, 6'd0, 6'd52, 6'd2};
    b2b_out = '{6'd1,  6'd5,  6'd0, 6'd22, 6'd9};
    b2b_oor = '{1'b0,  1'b1,  1'b0, 1'b0,  1'b0};
    p0 = pops;
    for (int k = 0; k < 5; k++)
      send(b2b_in[k], b2b_out[k], b2b_oor[k], 1'b1, acc_b2b[k]);
    in_valid = 1'b0;
    drain();
    for (int k = 1; k < 5; k++)
      chk("b2b_spacing", acc_b2b[k] - acc_b2b[k-1], W + 2);
    chk("b2b_result_count", pops - p0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
